uart_rx_decoder: RTL and testbench
==================================

Name: uart_rx_decoder

Overview:
- Synthesizable UART receiver for the 8N1 serial link on the board UART pins.
- Decodes serial frames into bytes and buffers them in a small FIFO with a valid/ready output handshake.
- Used on the FPGA side on UART_RXD.
- Also instantiated in simulation on UART_TXD as the byte-level monitor for the core's console output.

Parameters:
- CLKS_PER_TICK, 27: clk cycles per 1/16-bit oversample tick (50 MHz / (115200*16) rounded). Must be >= 2.
- DATA_BITS, 8: data bits per frame, 5..8. rx_data is zero-extended above DATA_BITS.
- FIFO_DEPTH, 8: receive FIFO entries. Power of 2, >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rxd  input  1  asynchronous serial line; idle high
- rx_data  output  8  byte at FIFO head
- rx_valid  output  1  FIFO not empty
- rx_ready  input  1  consumer accepts head byte when rx_valid & rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- parity_err  output  1  one-cycle pulse: parity mismatch (0 when feature compiled out)
- overflow  output  1  one-cycle pulse: completed byte dropped because FIFO full
- busy  output  1  receiver state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - All outputs 0; FIFO empty; state IDLE.
  - Synchronizer flops = 1; tick and bit counters = 0; armed = 0.
- Input sync: rxd passes through a 2-flop synchronizer; rxs = 2nd flop. All decisions use rxs only.
- Tick generator:
  - Counts 0..CLKS_PER_TICK-1; tick asserts for 1 cycle at wrap.
  - Free-running in every state except IDLE.
  - Cleared on the IDLE->START transition.
- Arm rule: armed sets once rxs = 1 is seen in IDLE. A start is detected only when armed. A line held low out of reset is ignored until it returns high.
- States and transitions:
  - IDLE: armed & rxs==0 -> START; sample counter = 0.
  - START: on the 8th tick (mid start bit):
    - rxs==1 -> IDLE (glitch rejected, nothing pushed, no error).
    - else -> DATA; sample counter = 0; bit counter = 0.
  - DATA: every 16th tick after mid-start, sample rxs and shift right into the shift register (LSB first). After DATA_BITS samples -> PARITY if feature enabled, else STOP.
  - PARITY: sample at the next 16th tick; compare; latch the mismatch -> STOP.
  - STOP: sample at the next 16th tick (mid stop bit).
    - rxs==1: push byte (unless a parity mismatch was latched, in which case pulse parity_err and discard) -> IDLE immediately. Back-to-back frames with a 1-bit stop are therefore received.
    - rxs==0: pulse frame_err, discard byte -> BREAK.
  - BREAK: wait for rxs==1 -> IDLE. Long breaks produce exactly one frame_err.
- Push latency: byte visible on rx_data/rx_valid the cycle after the mid-stop sample cycle.
- FIFO:
  - rx_data is the registered head.
  - Pop when rx_valid & rx_ready.
  - Push when full and no pop in the same cycle -> byte dropped, overflow pulses; FIFO contents unchanged.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when empty: push only (rx_valid was 0).
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Error pulses are never concurrent with a push of the same frame.
- Reset mid-frame: abandon the frame, empty the FIFO, clear armed.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is start + DATA_BITS + even-parity bit + stop.
  - Parity bit sampled in PARITY state.
  - Mismatch -> parity_err pulse; byte discarded.
  - STOP checks still apply; frame_err takes precedence and suppresses parity_err.
- Undefined: PARITY state is absent, parity_err is tied 0, frame is 8N1.

Test Plan:
- Basic receive: CLKS_PER_TICK=4 (64 clk/bit), rx_ready=1, send 0xA5 then 0x3C back-to-back -> rx_valid pulses twice, with rx_data 0xA5 then 0x3C. First pulse occurs 1 clk after the mid-stop sample. No error pulses.
- Glitch rejection: rxd low for 20 clk, then high -> busy asserts then returns to 0; no push, no frame_err.
- Framing error / break: send 0x55 with the stop bit low and rxd held low for 5 bit times -> exactly one frame_err pulse; FIFO empty. After rxd returns high, 0x12 is received correctly.
- FIFO full / overflow: rx_ready=0, send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 -> overflow pulses once, on byte 0x09. Then rx_ready=1 drains 0x01..0x08 in order, and rx_valid drops.
- Reset behaviour: assert reset for 1 clk mid-DATA of 0x77 with rxd still low -> outputs 0, FIFO empty. No start is accepted until rxd has been high; the next 0x42 is received.
- Parity (UART_RX_PARITY_EN defined): send 0x07 with parity bit 1 -> pushed; send 0x07 with parity bit 0 -> parity_err pulse, no push.

Source files
------------

// File: rtl/uart_rx_decoder.sv
// uart_rx_decoder: 16x oversampling UART receiver (start + DATA_BITS + stop).
// It decodes serial frames into bytes and queues them in a small FIFO that
// the consumer drains through a valid/ready handshake.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit to the
// frame. When the macro is undefined, parity_err is tied low.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   rxd        asynchronous serial line, idle high
//   rx_data    byte at the FIFO head (registered, zero-extended)
//   rx_valid   FIFO not empty
//   rx_ready   consumer accepts the head byte when rx_valid & rx_ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   parity_err one-cycle pulse: parity mismatch
//   overflow   one-cycle pulse: completed byte dropped, FIFO full
//   busy       receiver not idle
module uart_rx_decoder #(
  parameter int unsigned CLKS_PER_TICK = 27,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]           sync_q;
  logic [1:0]           live_q;
  logic                 rxs;
  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic                 tick_c;
  logic [3:0]           samp_q, samp_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic                 push_c;
  logic                 frame_err_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_c;
`endif

  // Two-flop synchronizer. The reset value of the flops is not a real line
  // sample, so live_q marks when both stages hold data taken from the pin;
  // arming waits for that so a line held low through reset stays ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      live_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], rxd};
      live_q <= {live_q[0], 1'b1};
    end
  end

  assign rxs = sync_q[1];

  // Receiver next-state, oversample counters and event strobes.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    push_c      = 1'b0;
    frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_c = 1'b0;
`endif
    tick_c = (state_q != S_IDLE) && (tick_q == TICK_W'(CLKS_PER_TICK - 1));
    if (state_q != S_IDLE) begin
      tick_d = tick_c ? '0 : tick_q + TICK_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (rxs && live_q[1]) armed_d = 1'b1;
        if (armed_q && !rxs) begin
          state_d = S_START;
          samp_d  = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_START: begin
        // Eighth tick lands mid start bit; a high line there was a glitch.
        if (tick_c) begin
          if (samp_q == 4'd7) begin
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              samp_d  = '0;
              bit_d   = '0;
            end
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        // Even parity: data plus parity bit must carry an even count of ones.
        if (tick_c) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            par_bad_d = ^{shift_q, rxs};
            state_d   = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick_c) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            if (rxs) begin
              state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) parity_err_c = 1'b1;
              else           push_c       = 1'b1;
`else
              push_c = 1'b1;
`endif
            end else begin
              frame_err_c = 1'b1;
              state_d     = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver state register and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      samp_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      busy      <= (state_d != S_IDLE);
      frame_err <= frame_err_c;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad_q  <= par_bad_d;
      parity_err <= parity_err_c;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Receive FIFO with a registered head byte.
  logic [7:0]       mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_nxt_c;
  logic [CNT_W-1:0] cnt_q, cnt_nxt_c;
  logic [7:0]       byte_c, head_c;
  logic             pop_c, full_c, wr_en_c, ovf_c;

  always_comb begin
    byte_c    = 8'(shift_q);
    pop_c     = rx_valid & rx_ready;
    full_c    = (cnt_q == CNT_W'(FIFO_DEPTH));
    wr_en_c   = push_c & (~full_c | pop_c);
    ovf_c     = push_c & full_c & ~pop_c;
    rd_nxt_c  = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_nxt_c = cnt_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
    // The slot being written becomes the head when nothing else is queued.
    if (cnt_nxt_c == '0)                          head_c = 8'h00;
    else if (wr_en_c && (wr_ptr_q == rd_nxt_c))   head_c = byte_c;
    else                                          head_c = mem[rd_nxt_c];
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= byte_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_nxt_c;
      cnt_q    <= cnt_nxt_c;
      rx_valid <= (cnt_nxt_c != '0);
      rx_data  <= head_c;
      overflow <= ovf_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed testbench for uart_rx_decoder with CLKS_PER_TICK=4 (64 clk/bit).
module tb_uart_rx_decoder;

  localparam int unsigned BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT = 675;  // start edge to rx_valid, 11-bit frame
`else
  localparam int unsigned LAT = 611;  // 9.5 bits + 2 sync + 1 detect
`endif

  logic       clk = 1'b0;
  logic       reset, rxd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overflow, busy;

  always #5 clk = ~clk;

  uart_rx_decoder #(.CLKS_PER_TICK(4), .DATA_BITS(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overflow(overflow), .busy(busy)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log: accepted bytes with their cycle, and pulse counts.
  logic [7:0]  got_q[$];
  int unsigned got_cyc_q[$];
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got_q.push_back(rx_data);
      got_cyc_q.push_back(cyc);
    end
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overflow)   ov_cnt++;
  end

  int vec_cnt = 0, err_cnt = 0;

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

  task automatic test_reset;
    reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
    repeat (4) @(posedge clk); #1;
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    vec_cnt++; if ({frame_err, parity_err, overflow} !== 3'b000) begin err_cnt++; $display("FAIL reset_pulses got %b want 000", {frame_err, parity_err, overflow}); end
    reset = 1'b0;
    repeat (4) @(posedge clk); #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int base, fe0, pe0, ov0;
    int unsigned t0;
    base = got_q.size(); fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(posedge clk); #1;
    vec_cnt++; if (got_q.size() - base != 2) begin err_cnt++; $display("FAIL basic_count got %0d want 2", got_q.size() - base); end
    vec_cnt++; if (got_q.size() < base + 1 || got_q[base] !== 8'hA5) begin err_cnt++; $display("FAIL basic_byte0 want a5"); end
    vec_cnt++; if (got_q.size() < base + 2 || got_q[base+1] !== 8'h3C) begin err_cnt++; $display("FAIL basic_byte1 want 3c"); end
    vec_cnt++; if (got_cyc_q.size() < base + 1 || got_cyc_q[base] - t0 != LAT) begin err_cnt++; $display("FAIL basic_latency want %0d clk", LAT); end
    vec_cnt++; if (fe_cnt + pe_cnt + ov_cnt != fe0 + pe0 + ov0) begin err_cnt++; $display("FAIL basic_no_err got %0d extra pulses want 0", fe_cnt + pe_cnt + ov_cnt - fe0 - pe0 - ov0); end
  endtask

  task automatic test_glitch;
    int base, fe0;
    base = got_q.size(); fe0 = fe_cnt;
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (10) @(posedge clk); #1;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL glitch_busy_on got %b want 1", busy); end
    repeat (10) @(posedge clk); #1;
    rxd = 1'b1;
    repeat (60) @(posedge clk); #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy_off got %b want 0", busy); end
    vec_cnt++; if (got_q.size() != base || rx_valid !== 1'b0) begin err_cnt++; $display("FAIL glitch_no_push got %0d bytes want 0", got_q.size() - base); end
    vec_cnt++; if (fe_cnt != fe0) begin err_cnt++; $display("FAIL glitch_no_frame_err got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_break;
    int base, fe0;
    base = got_q.size(); fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (4) drive_bit(1'b0);
    vec_cnt++; if (fe_cnt - fe0 != 1) begin err_cnt++; $display("FAIL break_frame_err got %0d want 1", fe_cnt - fe0); end
    vec_cnt++; if (got_q.size() != base || rx_valid !== 1'b0) begin err_cnt++; $display("FAIL break_fifo_empty got %0d bytes want 0", got_q.size() - base); end
    drive_bit(1'b1);
    send_frame(8'h12, 1'b1);
    repeat (20) @(posedge clk); #1;
    vec_cnt++; if (got_q.size() != base + 1 || got_q[base] !== 8'h12) begin err_cnt++; $display("FAIL break_recover want one byte 12"); end
    vec_cnt++; if (fe_cnt - fe0 != 1) begin err_cnt++; $display("FAIL break_single_err got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_overflow;
    int base, ov0;
    logic [7:0] exp_b;
    base = got_q.size(); ov0 = ov_cnt;
    rx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
    vec_cnt++; if (ov_cnt != ov0) begin err_cnt++; $display("FAIL ovf_early got %0d want 0", ov_cnt - ov0); end
    send_frame(8'h09, 1'b1);
    repeat (10) @(posedge clk); #1;
    vec_cnt++; if (ov_cnt - ov0 != 1) begin err_cnt++; $display("FAIL ovf_pulse got %0d want 1", ov_cnt - ov0); end
    vec_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin err_cnt++; $display("FAIL ovf_head got %b/%h want 1/01", rx_valid, rx_data); end
    rx_ready = 1'b1;
    repeat (20) @(posedge clk); #1;
    vec_cnt++; if (got_q.size() - base != 8) begin err_cnt++; $display("FAIL ovf_drain_count got %0d want 8", got_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'(i + 1);
      vec_cnt++;
      if (got_q.size() <= base + i || got_q[base+i] !== exp_b) begin
        err_cnt++; $display("FAIL ovf_drain_%0d want %h", i, exp_b);
      end
    end
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_empty got %b want 0", rx_valid); end
  endtask

  task automatic test_reset_mid;
    int base;
    base = got_q.size();
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    rxd = 1'b0;
    repeat (32) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vec_cnt++; if ({rx_valid, busy, frame_err, overflow} !== 4'b0000) begin err_cnt++; $display("FAIL rst_mid_outputs got %b want 0000", {rx_valid, busy, frame_err, overflow}); end
    vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL rst_mid_data got %h want 00", rx_data); end
    repeat (300) @(posedge clk); #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_not_armed got %b want 0", busy); end
    drive_bit(1'b1);
    send_frame(8'h42, 1'b1);
    repeat (20) @(posedge clk); #1;
    vec_cnt++; if (got_q.size() != base + 1 || got_q[base] !== 8'h42) begin err_cnt++; $display("FAIL rst_mid_next want one byte 42, got %0d bytes", got_q.size() - base); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int base, pe0;
    base = got_q.size(); pe0 = pe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (20) @(posedge clk); #1;
    vec_cnt++; if (got_q.size() != base + 1 || got_q[base] !== 8'h07) begin err_cnt++; $display("FAIL parity_good want one byte 07"); end
    vec_cnt++; if (pe_cnt != pe0) begin err_cnt++; $display("FAIL parity_good_err got %0d want 0", pe_cnt - pe0); end
    base = got_q.size();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (20) @(posedge clk); #1;
    vec_cnt++; if (pe_cnt - pe0 != 1) begin err_cnt++; $display("FAIL parity_bad_err got %0d want 1", pe_cnt - pe0); end
    vec_cnt++; if (got_q.size() != base) begin err_cnt++; $display("FAIL parity_bad_push got %0d bytes want 0", got_q.size() - base); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overflow();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
